// File: rtl/reg_writeback_pkg.sv
// Shared register-file types: write-port parameters, architectural register
// word, and the internal result bundle used to mux the two result sources.
package reg_file_inc;

  localparam int REG_ADDR_WIDTH = 5;

  typedef logic [31:0] arch_reg;

  typedef struct packed {
    logic                      write_enable;
    logic [REG_ADDR_WIDTH-1:0] addr_rd;
  } reg_file_write_params_t;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    arch_reg                   data;
  } wb_result_t;

endpackage

// File: rtl/reg_writeback_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, x0 never busy.
// A set and a clear to the same register at the same edge leave it busy.
module reg_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 i_set_valid,
  input  logic [ADDR_W-1:0]    i_set_addr,
  input  logic                 i_clr_valid,
  input  logic [ADDR_W-1:0]    i_clr_addr,
  input  logic [ADDR_W-1:0]    i_query_a_addr,
  output logic                 o_query_a_busy,
  input  logic [ADDR_W-1:0]    i_query_b_addr,
  output logic                 o_query_b_busy,
  output logic [2**ADDR_W-1:0] o_mask
);

  localparam int N = 2**ADDR_W;

  logic [N-1:0] r_busy;
  logic [N-1:0] w_next;

  // Next busy vector: clear first so a coincident set takes precedence.
  always_comb begin
    w_next = r_busy;
    if (i_clr_valid) w_next[i_clr_addr] = 1'b0;
    if (i_set_valid) w_next[i_set_addr] = 1'b1;
    w_next[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_busy <= '0;
    else          r_busy <= w_next;
  end

  assign o_query_a_busy = r_busy[i_query_a_addr];
  assign o_query_b_busy = r_busy[i_query_b_addr];
  assign o_mask         = r_busy;

endmodule

// File: rtl/reg_writeback.sv
// Writeback initiator: arbitrates load/execute results onto the single
// register-file write port, tracks pending writes and forwards the port.
//
// Handshakes: a transfer happens in any cycle where valid and ready are both
// 1 at the rising clock edge; valid never depends on ready, ready may depend
// on valid only as stated (ex_ready = !ld_valid, ld_ready is constant 1).
module reg_writeback #(
  parameter int REG_ADDR_WIDTH = reg_file_inc::REG_ADDR_WIDTH
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0]           issue_rd,
  output logic                                issue_ready,
  input  logic                                ex_valid,
  input  logic [REG_ADDR_WIDTH-1:0]           ex_rd,
  input  logic [31:0]                         ex_data,
  output logic                                ex_ready,
  input  logic                                ld_valid,
  input  logic [REG_ADDR_WIDTH-1:0]           ld_rd,
  input  logic [31:0]                         ld_data,
  output logic                                ld_ready,
  output reg_file_inc::reg_file_write_params_t write_params,
  output reg_file_inc::arch_reg               data_rd,
  input  logic [REG_ADDR_WIDTH-1:0]           query_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]           query_rs2,
  output logic                                busy_rs1,
  output logic                                busy_rs2,
  output logic                                fwd_valid_rs1,
  output logic                                fwd_valid_rs2,
  output logic [31:0]                         fwd_data_rs1,
  output logic [31:0]                         fwd_data_rs2,
  output logic [2**REG_ADDR_WIDTH-1:0]        busy_mask,
  output logic                                protocol_error
);

  logic [2**REG_ADDR_WIDTH-1:0]        w_mask;
  logic                                w_q1_busy;
  logic                                w_q2_busy;
  logic                                w_issue_fire;
  logic                                w_accept;
  logic                                w_commit;
  reg_file_inc::wb_result_t            w_result;
  reg_file_inc::reg_file_write_params_t r_write_params;
  reg_file_inc::arch_reg               r_data_rd;
  logic                                r_protocol_error;

  // A claim may be granted when the register is free or its write retires now.
  assign issue_ready  = !w_mask[issue_rd] |
                        (r_write_params.write_enable & (r_write_params.addr_rd == issue_rd));
  assign w_issue_fire = issue_valid & issue_ready & (issue_rd != '0);

  // Fixed priority: load always wins, execute waits while a load is offered.
  assign ld_ready = 1'b1;
  assign ex_ready = !ld_valid;

  // Select the accepted result; defaults to execute, overridden by load.
  always_comb begin
    w_result = '{rd: ex_rd, data: ex_data};
    if (ld_valid) w_result = '{rd: ld_rd, data: ld_data};
  end

  assign w_accept = ld_valid | ex_valid;
  assign w_commit = w_accept & (w_result.rd != '0);

  reg_scoreboard #(.ADDR_W(REG_ADDR_WIDTH)) u_scoreboard (
    .clock          (clock),
    .reset_n        (reset_n),
    .i_set_valid    (w_issue_fire),
    .i_set_addr     (issue_rd),
    .i_clr_valid    (r_write_params.write_enable),
    .i_clr_addr     (r_write_params.addr_rd),
    .i_query_a_addr (query_rs1),
    .o_query_a_busy (w_q1_busy),
    .i_query_b_addr (query_rs2),
    .o_query_b_busy (w_q2_busy),
    .o_mask         (w_mask)
  );

  // Write-port register: one result per cycle; results to x0 never write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_write_params <= '0;
      r_data_rd      <= '0;
    end else begin
      r_write_params.write_enable <= w_commit;
      if (w_accept) begin
        r_write_params.addr_rd <= w_result.rd;
        r_data_rd              <= w_result.data;
      end
    end
  end

  // Sticky flag for a result whose destination holds no pending claim.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                             r_protocol_error <= 1'b0;
    else if (w_commit && !w_mask[w_result.rd]) r_protocol_error <= 1'b1;
  end

  assign write_params   = r_write_params;
  assign data_rd        = r_data_rd;
  assign protocol_error = r_protocol_error;
  assign busy_mask      = w_mask;

  assign fwd_valid_rs1 = r_write_params.write_enable &
                         (r_write_params.addr_rd == query_rs1) & (query_rs1 != '0);
  assign fwd_valid_rs2 = r_write_params.write_enable &
                         (r_write_params.addr_rd == query_rs2) & (query_rs2 != '0);
  assign fwd_data_rs1  = r_data_rd;
  assign fwd_data_rs2  = r_data_rd;
  assign busy_rs1      = w_q1_busy & !fwd_valid_rs1;
  assign busy_rs2      = w_q2_busy & !fwd_valid_rs2;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: scoreboard, arbitration, forwarding,
// x0 handling, protocol error and asynchronous reset.
module tb_reg_writeback;

  logic        clock;
  logic        reset_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ex_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  reg_file_inc::reg_file_write_params_t write_params;
  reg_file_inc::arch_reg data_rd;
  logic [4:0]  query_rs1;
  logic [4:0]  query_rs2;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        fwd_valid_rs1;
  logic        fwd_valid_rs2;
  logic [31:0] fwd_data_rs1;
  logic [31:0] fwd_data_rs2;
  logic [31:0] busy_mask;
  logic        protocol_error;

  int tests_run = 0;
  int tests_failed = 0;

  reg_writeback dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_ready    (issue_ready),
    .ex_valid       (ex_valid),
    .ex_rd          (ex_rd),
    .ex_data        (ex_data),
    .ex_ready       (ex_ready),
    .ld_valid       (ld_valid),
    .ld_rd          (ld_rd),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .write_params   (write_params),
    .data_rd        (data_rd),
    .query_rs1      (query_rs1),
    .query_rs2      (query_rs2),
    .busy_rs1       (busy_rs1),
    .busy_rs2       (busy_rs2),
    .fwd_valid_rs1  (fwd_valid_rs1),
    .fwd_valid_rs2  (fwd_valid_rs2),
    .fwd_data_rs1   (fwd_data_rs1),
    .fwd_data_rs2   (fwd_data_rs2),
    .busy_mask      (busy_mask),
    .protocol_error (protocol_error)
  );

  // Clock: 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [4:0] addr,
                            input logic [31:0] data);
    check({tag, "_we"},   32'(write_params.write_enable), 32'(we));
    check({tag, "_addr"}, 32'(write_params.addr_rd),      32'(addr));
    check({tag, "_data"}, data_rd,                         data);
  endtask

  initial begin
    reset_n = 1'b0;
    issue_valid = 1'b0; issue_rd = '0;
    ex_valid = 1'b0; ex_rd = '0; ex_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    query_rs1 = '0; query_rs2 = '0;
    #2;
    check_port("rst", 1'b0, 5'd0, 32'h0);
    check("rst_mask",  busy_mask, 32'h0);
    check("rst_perr",  32'(protocol_error), 32'd0);
    check("rst_iready", 32'(issue_ready), 32'd1);
    check("rst_ldready", 32'(ld_ready), 32'd1);
    check("rst_exready", 32'(ex_ready), 32'd1);
    check("rst_fwd1", 32'(fwd_valid_rs1), 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // Basic execute result to r5.
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1 check("t1_iready", 32'(issue_ready), 32'd1);
    cyc();
    issue_valid = 1'b0;
    query_rs1 = 5'd5; query_rs2 = 5'd5;
    #1 check("t1_mask_set", busy_mask, 32'h0000_0020);
    check("t1_busy_rs1", 32'(busy_rs1), 32'd1);
    ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEAD_BEEF;
    #1 check("t1_exready", 32'(ex_ready), 32'd1);
    cyc();
    ex_valid = 1'b0;
    #1 check_port("t1_wr", 1'b1, 5'd5, 32'hDEAD_BEEF);
    check("t1_fwd1", 32'(fwd_valid_rs1), 32'd1);
    check("t1_fwd2", 32'(fwd_valid_rs2), 32'd1);
    check("t1_fwd_data", fwd_data_rs1, 32'hDEAD_BEEF);
    check("t1_busy_fwd", 32'(busy_rs1), 32'd0);
    cyc();
    check("t1_mask_clr", busy_mask, 32'h0);
    check("t1_we_drop", 32'(write_params.write_enable), 32'd0);
    query_rs1 = '0; query_rs2 = '0;

    // Simultaneous load and execute results.
    issue_valid = 1'b1; issue_rd = 5'd3;
    cyc();
    issue_rd = 5'd4;
    cyc();
    issue_valid = 1'b0;
    check("t2_mask", busy_mask, 32'h0000_0018);
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h0000_0033;
    ex_valid = 1'b1; ex_rd = 5'd4; ex_data = 32'h0000_0044;
    #1 check("t2_exready", 32'(ex_ready), 32'd0);
    check("t2_ldready", 32'(ld_ready), 32'd1);
    cyc();
    ld_valid = 1'b0;
    #1 check_port("t2_ld", 1'b1, 5'd3, 32'h0000_0033);
    check("t2_exready2", 32'(ex_ready), 32'd1);
    cyc();
    ex_valid = 1'b0;
    check_port("t2_ex", 1'b1, 5'd4, 32'h0000_0044);
    cyc();
    check("t2_mask_clr", busy_mask, 32'h0);

    // WAW stall and release on r7.
    issue_valid = 1'b1; issue_rd = 5'd7;
    cyc();
    #1 check("t3_iready_stall", 32'(issue_ready), 32'd0);
    ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 32'h0000_0077;
    cyc();
    ex_valid = 1'b0;
    #1 check_port("t3_wr", 1'b1, 5'd7, 32'h0000_0077);
    check("t3_iready_rel", 32'(issue_ready), 32'd1);
    cyc();
    issue_valid = 1'b0;
    check("t3_set_wins", busy_mask, 32'h0000_0080);
    ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 32'h0000_0078;
    cyc();
    ex_valid = 1'b0;
    cyc();
    check("t3_mask_clr", busy_mask, 32'h0);
    check("t3_perr", 32'(protocol_error), 32'd0);

    // x0 claim and result.
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1 check("t4_iready", 32'(issue_ready), 32'd1);
    cyc();
    issue_valid = 1'b0;
    check("t4_mask_claim", busy_mask, 32'h0);
    ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'h0000_1234;
    #1 check("t4_exready", 32'(ex_ready), 32'd1);
    cyc();
    ex_valid = 1'b0;
    #1 check("t4_we", 32'(write_params.write_enable), 32'd0);
    check("t4_mask", busy_mask, 32'h0);
    check("t4_perr", 32'(protocol_error), 32'd0);

    // Protocol error: load to r9 with no claim.
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h0000_0099;
    cyc();
    ld_valid = 1'b0;
    #1 check_port("t5_wr", 1'b1, 5'd9, 32'h0000_0099);
    check("t5_perr", 32'(protocol_error), 32'd1);
    cyc();
    cyc();
    check("t5_perr_hold", 32'(protocol_error), 32'd1);
    check("t5_mask", busy_mask, 32'h0);

    // Reset in the cycle after an execute handshake.
    issue_valid = 1'b1; issue_rd = 5'd12;
    cyc();
    issue_valid = 1'b0;
    check("t6_mask", busy_mask, 32'h0000_1000);
    ex_valid = 1'b1; ex_rd = 5'd12; ex_data = 32'h00C0_FFEE;
    cyc();
    ex_valid = 1'b0;
    check("t6_we_pre", 32'(write_params.write_enable), 32'd1);
    reset_n = 1'b0;
    #1 check_port("t6_rst", 1'b0, 5'd0, 32'h0);
    check("t6_mask", busy_mask, 32'h0);
    check("t6_perr", 32'(protocol_error), 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();
    check("t6_we_after", 32'(write_params.write_enable), 32'd0);
    check("t6_mask_after", busy_mask, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
